// File: rtl/fp_align_stage.sv
// ---------------------------------------------------------------------------
// fp_align_stage
//
// Two-stage exponent-alignment front end for an IEEE-754 adder/subtractor.
// Stage 1 decides which operand has the larger magnitude, swaps the pair so
// that operand is "big", and computes the exponent difference.
// Stage 2 right-shifts the small mantissa by that difference and folds every
// bit shifted out into a sticky bit (bit 0).
// NaN/Inf (exponent all ones) are treated as ordinary numbers here; their
// resolution happens further downstream.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       input handshake (operand pair)
//   i_data_a, i_data_b      IEEE-754 operands
//   i_op_sub                1 = A-B, 0 = A+B (inverts B's sign)
//   o_valid / i_ready       output handshake (aligned result)
//   o_sign_big/o_sign_small signs of larger / smaller magnitude operand
//   o_exp_big               effective exponent of the larger operand
//   o_exp_diff              effective exponent difference, big - small
//   o_man_big               {hidden, fraction, 3'b000}
//   o_man_small             aligned small mantissa, sticky in bit 0
//   o_eff_sub               effective subtraction (sign_big ^ sign_small)
// ---------------------------------------------------------------------------
module fp_align_stage #(
    parameter int SIZE_EXP = 8,
    parameter int SIZE_MAN = 23
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [SIZE_EXP+SIZE_MAN:0] i_data_a,
    input  logic [SIZE_EXP+SIZE_MAN:0] i_data_b,
    input  logic                       i_op_sub,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_sign_big,
    output logic                       o_sign_small,
    output logic [SIZE_EXP-1:0]        o_exp_big,
    output logic [SIZE_EXP-1:0]        o_exp_diff,
    output logic [SIZE_MAN+3:0]        o_man_big,
    output logic [SIZE_MAN+3:0]        o_man_small,
    output logic                       o_eff_sub
);

    localparam int W  = SIZE_MAN + 4;
    localparam int DW = 1 + SIZE_EXP + SIZE_MAN;
    localparam logic [SIZE_EXP-1:0] EXP_ONE = SIZE_EXP'(1);

    // Handshake
    logic s1Valid_q, s1Valid_d;
    logic s2Valid_q, s2Valid_d;
    logic s1Load, s2Load, accept;

    // Operand decode / swap (combinational, feeds stage 1)
    logic                signA, signB;
    logic [SIZE_EXP-1:0] expA, expB, effExpA, effExpB;
    logic [SIZE_MAN:0]   manA, manB;
    logic                aIsBig;
    logic                signBigC, signSmallC;
    logic [SIZE_EXP-1:0] expBigC, expSmallC, expDiffC;
    logic [SIZE_MAN:0]   manBigC, manSmallC;

    // Stage 1 registers
    logic                s1SignBig_q, s1SignSmall_q;
    logic [SIZE_EXP-1:0] s1ExpBig_q, s1ExpDiff_q;
    logic [W-1:0]        s1ManBig_q, s1ManSmall_q;

    // Alignment shifter (combinational, feeds stage 2)
    logic [W-1:0]        shifted;
    logic                sticky;
    logic [W-1:0]        alignedSmall;

    // Stage 2 registers
    logic                s2SignBig_q, s2SignSmall_q;
    logic [SIZE_EXP-1:0] s2ExpBig_q, s2ExpDiff_q;
    logic [W-1:0]        s2ManBig_q, s2ManSmall_q;

    // Stage 2 drains when empty or when downstream takes its result; stage 1
    // may only advance into a stage 2 that is loading (or when itself empty).
    assign s2Load  = !s2Valid_q || i_ready;
    assign s1Load  = !s1Valid_q || s2Load;
    assign o_ready = s1Load;
    assign accept  = i_valid && s1Load;

    assign s1Valid_d = s1Load ? i_valid   : s1Valid_q;
    assign s2Valid_d = s2Load ? s1Valid_q : s2Valid_q;

    // Denormals get effective exponent 1 and no hidden bit, so they line up
    // with the smallest normal. Magnitude compare uses the effective exponent
    // first, then {hidden, fraction}; on a full tie A stays big.
    always_comb begin
        signA   = i_data_a[DW-1];
        signB   = i_data_b[DW-1] ^ i_op_sub;
        expA    = i_data_a[DW-2 -: SIZE_EXP];
        expB    = i_data_b[DW-2 -: SIZE_EXP];
        effExpA = (expA == '0) ? EXP_ONE : expA;
        effExpB = (expB == '0) ? EXP_ONE : expB;
        manA    = {(expA != '0), i_data_a[SIZE_MAN-1:0]};
        manB    = {(expB != '0), i_data_b[SIZE_MAN-1:0]};
        aIsBig  = (effExpA > effExpB) || ((effExpA == effExpB) && (manA >= manB));
        if (aIsBig) begin
            signBigC   = signA;
            signSmallC = signB;
            expBigC    = effExpA;
            expSmallC  = effExpB;
            manBigC    = manA;
            manSmallC  = manB;
        end else begin
            signBigC   = signB;
            signSmallC = signA;
            expBigC    = effExpB;
            expSmallC  = effExpA;
            manBigC    = manB;
            manSmallC  = manA;
        end
        // Two's-complement subtract; big >= small so the result is never negative.
        expDiffC = expBigC + ~expSmallC + EXP_ONE;
    end

    // Stage 1 valid and data; data only moves on an accepted pair.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1Valid_q     <= 1'b0;
            s1SignBig_q   <= 1'b0;
            s1SignSmall_q <= 1'b0;
            s1ExpBig_q    <= '0;
            s1ExpDiff_q   <= '0;
            s1ManBig_q    <= '0;
            s1ManSmall_q  <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            if (accept) begin
                s1SignBig_q   <= signBigC;
                s1SignSmall_q <= signSmallC;
                s1ExpBig_q    <= expBigC;
                s1ExpDiff_q   <= expDiffC;
                s1ManBig_q    <= {manBigC, 3'b000};
                s1ManSmall_q  <= {manSmallC, 3'b000};
            end
        end
    end

    // Right shift with sticky: bit 0 collects the pre-shift bit 0 and every
    // bit pushed off the end. A shift of W or more leaves only the sticky.
    always_comb begin
        shifted = s1ManSmall_q >> s1ExpDiff_q;
        sticky  = s1ManSmall_q[0];
        for (int i = 1; i < W; i++) begin
            if (i < int'(s1ExpDiff_q)) begin
                sticky = sticky | s1ManSmall_q[i];
            end
        end
        if (int'(s1ExpDiff_q) >= W) begin
            alignedSmall = {{(W-1){1'b0}}, |s1ManSmall_q};
        end else begin
            alignedSmall = {shifted[W-1:1], shifted[0] | sticky};
        end
    end

    // Stage 2 valid and data; data holds whenever downstream stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2Valid_q     <= 1'b0;
            s2SignBig_q   <= 1'b0;
            s2SignSmall_q <= 1'b0;
            s2ExpBig_q    <= '0;
            s2ExpDiff_q   <= '0;
            s2ManBig_q    <= '0;
            s2ManSmall_q  <= '0;
        end else begin
            s2Valid_q <= s2Valid_d;
            if (s2Load && s1Valid_q) begin
                s2SignBig_q   <= s1SignBig_q;
                s2SignSmall_q <= s1SignSmall_q;
                s2ExpBig_q    <= s1ExpBig_q;
                s2ExpDiff_q   <= s1ExpDiff_q;
                s2ManBig_q    <= s1ManBig_q;
                s2ManSmall_q  <= alignedSmall;
            end
        end
    end

    assign o_valid      = s2Valid_q;
    assign o_sign_big   = s2SignBig_q;
    assign o_sign_small = s2SignSmall_q;
    assign o_exp_big    = s2ExpBig_q;
    assign o_exp_diff   = s2ExpDiff_q;
    assign o_man_big    = s2ManBig_q;
    assign o_man_small  = s2ManSmall_q;
    assign o_eff_sub    = s2SignBig_q ^ s2SignSmall_q;

endmodule

// File: tb/tb_fp_align_stage.sv
// ---------------------------------------------------------------------------
// tb_fp_align_stage
//
// Directed bench for fp_align_stage. Each test task drives its own stimulus
// and compares the packed output tuple against hand-computed constants:
//   {sign_big, sign_small, eff_sub, exp_big, exp_diff, man_big, man_small}
// ---------------------------------------------------------------------------
module tb_fp_align_stage;

    logic        clk;
    logic        rstN;
    logic        iValid;
    logic        oReady;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        opSub;
    logic        oValid;
    logic        iReady;
    logic        signBig;
    logic        signSmall;
    logic [7:0]  expBig;
    logic [7:0]  expDiff;
    logic [26:0] manBig;
    logic [26:0] manSmall;
    logic        effSub;
    logic [72:0] outTuple;

    int numCompared   = 0;
    int numMismatched = 0;

    // Directed vector table
    logic [31:0] vecA     [8];
    logic [31:0] vecB     [8];
    logic        vecSub   [8];
    logic [72:0] expTuple [8];
    string       vecName  [8];

    fp_align_stage #(
        .SIZE_EXP(8),
        .SIZE_MAN(23)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_valid     (iValid),
        .o_ready     (oReady),
        .i_data_a    (dataA),
        .i_data_b    (dataB),
        .i_op_sub    (opSub),
        .o_valid     (oValid),
        .i_ready     (iReady),
        .o_sign_big  (signBig),
        .o_sign_small(signSmall),
        .o_exp_big   (expBig),
        .o_exp_diff  (expDiff),
        .o_man_big   (manBig),
        .o_man_small (manSmall),
        .o_eff_sub   (effSub)
    );

    assign outTuple = {signBig, signSmall, effSub, expBig, expDiff, manBig, manSmall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [72:0] mkTuple(input logic sb, input logic ss, input logic es,
                                            input logic [7:0] eb, input logic [7:0] ed,
                                            input logic [26:0] mb, input logic [26:0] ms);
        return {sb, ss, es, eb, ed, mb, ms};
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub);
        iValid = 1'b1;
        dataA  = a;
        dataB  = b;
        opSub  = sub;
    endtask

    task automatic test_reset();
        rstN   = 1'b0;
        iValid = 1'b0;
        iReady = 1'b1;
        dataA  = '0;
        dataB  = '0;
        opSub  = 1'b0;
        #12;
        numCompared++;
        if (oValid !== 1'b0) begin
            numMismatched++;
            $display("[TB] FAIL reset_o_valid: got %b expected 0", oValid);
        end
        numCompared++;
        if (oReady !== 1'b1) begin
            numMismatched++;
            $display("[TB] FAIL reset_o_ready: got %b expected 1", oReady);
        end
        numCompared++;
        if (outTuple !== 73'h0) begin
            numMismatched++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", outTuple);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        numCompared++;
        if (oReady !== 1'b1) begin
            numMismatched++;
            $display("[TB] FAIL post_reset_o_ready: got %b expected 1", oReady);
        end
    endtask

    task automatic test_alignment();
        iReady = 1'b1;
        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #1;
            applyStimulus(vecA[v], vecB[v], vecSub[v]);
            @(posedge clk); #1;
            iValid = 1'b0;
            numCompared++;
            if (oValid !== 1'b0) begin
                numMismatched++;
                $display("[TB] FAIL latency_early_%s: o_valid got %b expected 0", vecName[v], oValid);
            end
            @(posedge clk); #1;
            numCompared++;
            if (oValid !== 1'b1) begin
                numMismatched++;
                $display("[TB] FAIL latency_%s: o_valid got %b expected 1", vecName[v], oValid);
            end
            numCompared++;
            if (outTuple !== expTuple[v]) begin
                numMismatched++;
                $display("[TB] FAIL align_%s: got %h expected %h", vecName[v], outTuple, expTuple[v]);
            end
        end
        @(posedge clk); #1;
    endtask

    // Streams vectors 0..3; downstream stalls for the first stallCycles cycles.
    task automatic test_back_to_back(input int stallCycles);
        int prodIdx  = 0;
        int consIdx  = 0;
        int cyc      = 0;
        int lastTake = -1;
        logic acc;
        logic take;
        @(posedge clk); #1;
        applyStimulus(vecA[0], vecB[0], vecSub[0]);
        iReady = (stallCycles == 0);
        while (consIdx < 4 && cyc < 40) begin
            @(negedge clk);
            acc  = iValid && oReady;
            take = oValid && iReady;
            if (stallCycles == 0 && iValid) begin
                numCompared++;
                if (oReady !== 1'b1) begin
                    numMismatched++;
                    $display("[TB] FAIL stream_bubble_cyc%0d: o_ready got %b expected 1", cyc, oReady);
                end
            end
            if (stallCycles > 0 && prodIdx == 2 && !iReady) begin
                numCompared++;
                if (oReady !== 1'b0) begin
                    numMismatched++;
                    $display("[TB] FAIL stall_o_ready_cyc%0d: got %b expected 0", cyc, oReady);
                end
            end
            if (oValid) begin
                numCompared++;
                if (outTuple !== expTuple[consIdx]) begin
                    numMismatched++;
                    $display("[TB] FAIL stream_s%0d_result%0d_cyc%0d: got %h expected %h",
                             stallCycles, consIdx, cyc, outTuple, expTuple[consIdx]);
                end
            end
            if (take) begin
                lastTake = cyc;
                consIdx++;
            end
            if (acc) prodIdx++;
            @(posedge clk); #1;
            cyc++;
            iValid = (prodIdx < 4);
            if (prodIdx < 4) applyStimulus(vecA[prodIdx], vecB[prodIdx], vecSub[prodIdx]);
            iReady = (cyc >= stallCycles);
        end
        iValid = 1'b0;
        iReady = 1'b1;
        numCompared++;
        if (consIdx != 4) begin
            numMismatched++;
            $display("[TB] FAIL stream_s%0d_count: got %0d results expected 4", stallCycles, consIdx);
        end
        if (stallCycles == 0) begin
            numCompared++;
            if (lastTake != 5) begin
                numMismatched++;
                $display("[TB] FAIL stream_last_cycle: got %0d expected 5", lastTake);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        iReady = 1'b0;
        @(posedge clk); #1;
        applyStimulus(vecA[1], vecB[1], vecSub[1]);
        @(posedge clk); #1;
        applyStimulus(vecA[2], vecB[2], vecSub[2]);
        @(posedge clk); #1;
        iValid = 1'b0;
        numCompared++;
        if (oValid !== 1'b1 || oReady !== 1'b0) begin
            numMismatched++;
            $display("[TB] FAIL midreset_full: valid/ready got %b%b expected 10", oValid, oReady);
        end
        #3;
        rstN = 1'b0;
        #1;
        numCompared++;
        if (oValid !== 1'b0) begin
            numMismatched++;
            $display("[TB] FAIL midreset_o_valid: got %b expected 0", oValid);
        end
        numCompared++;
        if (oReady !== 1'b1) begin
            numMismatched++;
            $display("[TB] FAIL midreset_o_ready: got %b expected 1", oReady);
        end
        numCompared++;
        if (outTuple !== 73'h0) begin
            numMismatched++;
            $display("[TB] FAIL midreset_outputs: got %h expected 0", outTuple);
        end
        @(negedge clk);
        rstN   = 1'b1;
        iReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            numCompared++;
            if (oValid !== 1'b0) begin
                numMismatched++;
                $display("[TB] FAIL midreset_stale_cyc%0d: o_valid got %b expected 0", c, oValid);
            end
        end
        @(posedge clk); #1;
        applyStimulus(vecA[0], vecB[0], vecSub[0]);
        @(posedge clk); #1;
        iValid = 1'b0;
        @(posedge clk); #1;
        numCompared++;
        if (oValid !== 1'b1 || outTuple !== expTuple[0]) begin
            numMismatched++;
            $display("[TB] FAIL midreset_first_pair: valid %b got %h expected %h",
                     oValid, outTuple, expTuple[0]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vecName[0] = "basic";    vecA[0] = 32'h3F800000; vecB[0] = 32'h40000000; vecSub[0] = 1'b0;
        expTuple[0] = mkTuple(1'b0, 1'b0, 1'b0, 8'h80, 8'd1,  27'h4000000, 27'h2000000);
        vecName[1] = "sticky";   vecA[1] = 32'h4B800000; vecB[1] = 32'h3F800001; vecSub[1] = 1'b0;
        expTuple[1] = mkTuple(1'b0, 1'b0, 1'b0, 8'h97, 8'd24, 27'h4000000, 27'h0000005);
        vecName[2] = "saturate"; vecA[2] = 32'h4F000000; vecB[2] = 32'h3F800000; vecSub[2] = 1'b0;
        expTuple[2] = mkTuple(1'b0, 1'b0, 1'b0, 8'h9E, 8'd31, 27'h4000000, 27'h0000001);
        vecName[3] = "tie_sub";  vecA[3] = 32'h3F800000; vecB[3] = 32'h3FC00000; vecSub[3] = 1'b1;
        expTuple[3] = mkTuple(1'b1, 1'b0, 1'b1, 8'h7F, 8'd0,  27'h6000000, 27'h4000000);
        vecName[4] = "denormal"; vecA[4] = 32'h00000001; vecB[4] = 32'h00800000; vecSub[4] = 1'b0;
        expTuple[4] = mkTuple(1'b0, 1'b0, 1'b0, 8'h01, 8'd0,  27'h4000000, 27'h0000008);
        vecName[5] = "equal";    vecA[5] = 32'h40000000; vecB[5] = 32'hC0000000; vecSub[5] = 1'b0;
        expTuple[5] = mkTuple(1'b0, 1'b1, 1'b1, 8'h80, 8'd0,  27'h4000000, 27'h4000000);
        vecName[6] = "exp_ff";   vecA[6] = 32'h7F800000; vecB[6] = 32'h3F800000; vecSub[6] = 1'b0;
        expTuple[6] = mkTuple(1'b0, 1'b0, 1'b0, 8'hFF, 8'd128, 27'h4000000, 27'h0000001);
        vecName[7] = "diff25";   vecA[7] = 32'h4C000000; vecB[7] = 32'h3F800000; vecSub[7] = 1'b0;
        expTuple[7] = mkTuple(1'b0, 1'b0, 1'b0, 8'h98, 8'd25, 27'h4000000, 27'h0000002);

        test_reset();
        test_alignment();
        test_back_to_back(0);
        test_back_to_back(3);
        test_mid_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
